// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared types and defaults for the pipeline sequencer pipe_ctrl.
//   ctrl_state_t : FSM state encoding (RUN=0, FLUSH=1, REFILL=2, 3 unused)
//   stage_ctrl_t : per-stage stall/bubble/flush bundle, kept packed so it can
//                  later be carried through an interface unchanged
//   sat_inc      : saturating 32-bit increment used by the perf counters
// Optional feature macro: PIPE_CTRL_PERF_EN (see pipe_ctrl.sv).

package pipe_ctrl_pkg;

  localparam int ADDR_W_DEF       = 32;
  localparam int FLUSH_CYCLES_DEF = 2;
  localparam int REFILL_MAX_DEF   = 8;
  localparam int PERF_W           = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    REFILL = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic stall_if;
    logic stall_ifid;
    logic stall_id;
    logic stall_idex;
    logic bubble_idex;
    logic flush_front;
    logic flush_rob;
  } stage_ctrl_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] value);
    return (value == {PERF_W{1'b1}}) ? value : value + {{(PERF_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// pipe_ctrl_perf
// Performance counter bank for pipe_ctrl; only exists when PIPE_CTRL_PERF_EN
// is defined. All counters are 32-bit, saturating, cleared by reset.
// Ports:
//   clk                in  clock
//   rst                in  asynchronous reset, active-low
//   stall_if           in  fetch stalled this cycle
//   redirect           in  redirect accepted this cycle
//   in_refill          in  sequencer currently in REFILL
//   perf_stall_cycles  out cycles with stall_if=1
//   perf_flush_count   out number of accepted redirects
//   perf_refill_cycles out cycles spent in REFILL

`ifdef PIPE_CTRL_PERF_EN
module pipe_ctrl_perf
  import pipe_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              redirect,
  input  logic              in_refill,
  output logic [PERF_W-1:0] perf_stall_cycles,
  output logic [PERF_W-1:0] perf_flush_count,
  output logic [PERF_W-1:0] perf_refill_cycles
);

  // Each counter advances once per cycle in which its event is present.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cycles  <= '0;
      perf_flush_count   <= '0;
      perf_refill_cycles <= '0;
    end else begin
      if (stall_if)  perf_stall_cycles  <= sat_inc(perf_stall_cycles);
      if (redirect)  perf_flush_count   <= sat_inc(perf_flush_count);
      if (in_refill) perf_refill_cycles <= sat_inc(perf_refill_cycles);
    end
  end

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Central pipeline sequencer for cpu_core. Arbitrates stall requests from
// ID/EX and redirects from ROB commit, and drives the per-stage stall, bubble
// and flush controls plus the IF fetch redirect.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   id_stall_req        ID cannot issue
//   ex_stall_req        EX multi-cycle unit busy
//   rob_redirect_valid  1-cycle redirect pulse from ROB commit
//   rob_redirect_pc     redirect target
//   if_fetch_valid      IF produced a valid instruction
//   stall_if/ifid/id/idex, bubble_idex   combinational stage controls
//   flush_front, flush_rob               registered flush controls
//   jump_ce, jump_pc                     registered fetch redirect
//   ctrl_state                           FSM state for debug
// Optional feature: define PIPE_CTRL_PERF_EN to add perf_stall_cycles,
// perf_flush_count and perf_refill_cycles (saturating 32-bit counters).

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int REFILL_MAX   = REFILL_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_stall_req,
  input  logic              ex_stall_req,
  input  logic              rob_redirect_valid,
  input  logic [ADDR_W-1:0] rob_redirect_pc,
  input  logic              if_fetch_valid,
  output logic              stall_if,
  output logic              stall_ifid,
  output logic              stall_id,
  output logic              stall_idex,
  output logic              bubble_idex,
  output logic              flush_front,
  output logic              flush_rob,
  output logic              jump_ce,
  output logic [ADDR_W-1:0] jump_pc,
  output logic [1:0]        ctrl_state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cycles,
  output logic [PERF_W-1:0] perf_flush_count,
  output logic [PERF_W-1:0] perf_refill_cycles
`endif
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int RF_W = (REFILL_MAX > 1) ? $clog2(REFILL_MAX) : 1;
  localparam logic [FC_W-1:0] FLUSH_LOAD  = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [RF_W-1:0] REFILL_LAST = RF_W'(REFILL_MAX - 1);

  ctrl_state_t       state_q, state_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [RF_W-1:0]   refill_cnt_q, refill_cnt_d;
  logic              jump_ce_q;
  logic [ADDR_W-1:0] jump_pc_q;
  logic              flush_q;
  stage_ctrl_t       ctrl;

  // State register plus the registered redirect/flush outputs. The flush
  // flag is simply "next state is FLUSH", so it rises with the redirect and
  // falls on the same edge that leaves FLUSH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      flush_cnt_q  <= '0;
      refill_cnt_q <= '0;
      jump_ce_q    <= 1'b0;
      jump_pc_q    <= '0;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      refill_cnt_q <= refill_cnt_d;
      jump_ce_q    <= rob_redirect_valid;
      flush_q      <= (state_d == FLUSH);
      if (rob_redirect_valid) jump_pc_q <= rob_redirect_pc;
    end
  end

  // Next-state logic. A redirect wins in every state and (re)starts FLUSH
  // with a full count; FLUSH counts down to zero before moving to REFILL;
  // REFILL waits for the first fetch but gives up after REFILL_MAX cycles.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    refill_cnt_d = refill_cnt_q;
    if (rob_redirect_valid) begin
      state_d     = FLUSH;
      flush_cnt_d = FLUSH_LOAD;
    end else begin
      case (state_q)
        RUN: begin
          state_d = RUN;
        end
        FLUSH: begin
          if (flush_cnt_q == '0) begin
            state_d      = REFILL;
            refill_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q - 1'b1;
          end
        end
        REFILL: begin
          if (if_fetch_valid || (refill_cnt_q == REFILL_LAST)) begin
            state_d = RUN;
          end else begin
            refill_cnt_d = refill_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // Stage controls. Stalls are gated by rst so they read 0 during reset even
  // though the request inputs may be high, and are suppressed whenever a
  // redirect is present since the front end is about to be flushed anyway.
  always_comb begin
    ctrl             = '0;
    ctrl.flush_front = flush_q;
    ctrl.flush_rob   = flush_q;
    if (rst && !rob_redirect_valid && ((state_q == RUN) || (state_q == REFILL))) begin
      if (ex_stall_req) begin
        ctrl.stall_if   = 1'b1;
        ctrl.stall_ifid = 1'b1;
        ctrl.stall_id   = 1'b1;
        ctrl.stall_idex = 1'b1;
      end else if (id_stall_req) begin
        ctrl.stall_if    = 1'b1;
        ctrl.stall_ifid  = 1'b1;
        ctrl.stall_id    = 1'b1;
        ctrl.bubble_idex = 1'b1;
      end
    end
  end

  assign stall_if    = ctrl.stall_if;
  assign stall_ifid  = ctrl.stall_ifid;
  assign stall_id    = ctrl.stall_id;
  assign stall_idex  = ctrl.stall_idex;
  assign bubble_idex = ctrl.bubble_idex;
  assign flush_front = ctrl.flush_front;
  assign flush_rob   = ctrl.flush_rob;
  assign jump_ce     = jump_ce_q;
  assign jump_pc     = jump_pc_q;
  assign ctrl_state  = state_q;

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf u_perf (
    .clk                (clk),
    .rst                (rst),
    .stall_if           (ctrl.stall_if),
    .redirect           (rob_redirect_valid),
    .in_refill          (state_q == REFILL),
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_flush_count   (perf_flush_count),
    .perf_refill_cycles (perf_refill_cycles)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl. Each cycle the stimulus side drives the
// inputs, computes the expected outputs from a cycle-level model of the
// sequencer (mode, flush cycles left, refill age) and queues them; a monitor
// on the falling edge pops and compares against the DUT.

module tb_pipe_ctrl;

  localparam int AW = 32;
  localparam int FC = 2;
  localparam int RM = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_stall_req;
  logic          ex_stall_req;
  logic          rob_redirect_valid;
  logic [AW-1:0] rob_redirect_pc;
  logic          if_fetch_valid;
  logic          stall_if;
  logic          stall_ifid;
  logic          stall_id;
  logic          stall_idex;
  logic          bubble_idex;
  logic          flush_front;
  logic          flush_rob;
  logic          jump_ce;
  logic [AW-1:0] jump_pc;
  logic [1:0]    ctrl_state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]   perf_stall_cycles;
  logic [31:0]   perf_flush_count;
  logic [31:0]   perf_refill_cycles;
`endif

  typedef struct packed {
    logic [4:0]    stalls;
    logic [1:0]    flushes;
    logic          jce;
    logic [AW-1:0] jpc;
    logic [1:0]    st;
`ifdef PIPE_CTRL_PERF_EN
    logic [95:0]   perf;
`endif
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0=RUN 1=FLUSH 2=REFILL
  int          m_mode = 0;
  int          m_flush_left = 0;
  int          m_refill_age = 0;
  logic        m_jce = 1'b0;
  logic [31:0] m_jpc = '0;
  int          m_pstall = 0;
  int          m_pflush = 0;
  int          m_prefill = 0;

  pipe_ctrl #(
    .ADDR_W       (AW),
    .FLUSH_CYCLES (FC),
    .REFILL_MAX   (RM)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .id_stall_req       (id_stall_req),
    .ex_stall_req       (ex_stall_req),
    .rob_redirect_valid (rob_redirect_valid),
    .rob_redirect_pc    (rob_redirect_pc),
    .if_fetch_valid     (if_fetch_valid),
    .stall_if           (stall_if),
    .stall_ifid         (stall_ifid),
    .stall_id           (stall_id),
    .stall_idex         (stall_idex),
    .bubble_idex        (bubble_idex),
    .flush_front        (flush_front),
    .flush_rob          (flush_rob),
    .jump_ce            (jump_ce),
    .jump_pc            (jump_pc),
    .ctrl_state         (ctrl_state)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_flush_count   (perf_flush_count),
    .perf_refill_cycles (perf_refill_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge, queue what the
  // outputs must look like during that cycle, then step the model to the
  // state it will hold after the next rising edge.
  task automatic applyStimulus(input logic r, input logic id, input logic ex,
                               input logic rv, input logic [31:0] pc, input logic fv);
    exp_t e;
    @(posedge clk);
    #1;
    rst                = r;
    id_stall_req       = id;
    ex_stall_req       = ex;
    rob_redirect_valid = rv;
    rob_redirect_pc    = pc;
    if_fetch_valid     = fv;
    if (!r) begin
      m_mode = 0; m_flush_left = 0; m_refill_age = 0;
      m_jce = 1'b0; m_jpc = '0;
      m_pstall = 0; m_pflush = 0; m_prefill = 0;
    end
    e = '0;
    e.jpc = m_jpc;
    if (r) begin
      e.st      = 2'(m_mode);
      e.jce     = m_jce;
      e.flushes = (m_mode == 1) ? 2'b11 : 2'b00;
      if (m_mode != 1 && !rv) begin
        if (ex)      e.stalls = 5'b11110;
        else if (id) e.stalls = 5'b11101;
      end
    end
`ifdef PIPE_CTRL_PERF_EN
    e.perf = {32'(m_pstall), 32'(m_pflush), 32'(m_prefill)};
`endif
    sb.push_back(e);
    if (r) begin
      if (e.stalls[4]) m_pstall++;
      if (rv) m_pflush++;
      if (m_mode == 2) m_prefill++;
      m_jce = rv;
      if (rv) begin
        m_jpc = pc;
        m_mode = 1;
        m_flush_left = FC;
      end else if (m_mode == 1) begin
        m_flush_left--;
        if (m_flush_left == 0) begin
          m_mode = 2;
          m_refill_age = 0;
        end
      end else if (m_mode == 2) begin
        m_refill_age++;
        if (fv || m_refill_age == RM) m_mode = 0;
      end
    end
  endtask

  task automatic checkOutput(input exp_t e);
    logic [4:0] a_stalls;
    logic [1:0] a_flushes;
    a_stalls  = {stall_if, stall_ifid, stall_id, stall_idex, bubble_idex};
    a_flushes = {flush_front, flush_rob};
    n_checks++;
    if (a_stalls !== e.stalls) begin
      n_fail++;
      $display("[TB] FAIL stalls @%0t: got %b expected %b", $time, a_stalls, e.stalls);
    end
    n_checks++;
    if (a_flushes !== e.flushes) begin
      n_fail++;
      $display("[TB] FAIL flushes @%0t: got %b expected %b", $time, a_flushes, e.flushes);
    end
    n_checks++;
    if (jump_ce !== e.jce) begin
      n_fail++;
      $display("[TB] FAIL jump_ce @%0t: got %b expected %b", $time, jump_ce, e.jce);
    end
    n_checks++;
    if (jump_pc !== e.jpc) begin
      n_fail++;
      $display("[TB] FAIL jump_pc @%0t: got %h expected %h", $time, jump_pc, e.jpc);
    end
    n_checks++;
    if (ctrl_state !== e.st) begin
      n_fail++;
      $display("[TB] FAIL ctrl_state @%0t: got %0d expected %0d", $time, ctrl_state, e.st);
    end
`ifdef PIPE_CTRL_PERF_EN
    n_checks++;
    if ({perf_stall_cycles, perf_flush_count, perf_refill_cycles} !== e.perf) begin
      n_fail++;
      $display("[TB] FAIL perf @%0t: got %0d/%0d/%0d expected %0d/%0d/%0d", $time,
               perf_stall_cycles, perf_flush_count, perf_refill_cycles,
               e.perf[95:64], e.perf[63:32], e.perf[31:0]);
    end
`endif
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  initial begin
    rst = 1'b0; id_stall_req = 1'b1; ex_stall_req = 1'b1;
    rob_redirect_valid = 1'b1; rob_redirect_pc = '1; if_fetch_valid = 1'b1;

    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
    repeat (12) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_ABC0, 1'b0);
    repeat (12) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0400, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0500, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(59) != 0),
                    ($urandom_range(2) == 0),
                    ($urandom_range(3) == 0),
                    ($urandom_range(9) == 0),
                    $urandom,
                    ($urandom_range(4) == 0));
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for cpu_core. Collects stall requests from ID and EX and redirect requests from ROB commit. Drives per-stage stall, bubble and flush controls to IF, IFID, ID, IDEX and ROB, plus the fetch redirect (jump_ce/jump_pc) into IF. It replaces the ad-hoc jump_ce/stall registers in cpu_core.

Parameters:
ADDR_W, 32, width of redirect PC
FLUSH_CYCLES, 2, cycles flush_* held asserted after a redirect (>=1)
REFILL_MAX, 8, max cycles waited in REFILL for first valid fetch before forcing RUN

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous reset, active-low (0 = reset)
id_stall_req  in  1  ID cannot issue (ROB/RS full)
ex_stall_req  in  1  EX multi-cycle unit busy
rob_redirect_valid  in  1  ROB commit mispredict/exception, 1-cycle pulse
rob_redirect_pc  in  ADDR_W  target PC, valid with rob_redirect_valid
if_fetch_valid  in  1  IF produced a valid instruction this cycle
stall_if  out  1  hold PC
stall_ifid  out  1  hold IFID register
stall_id  out  1  hold ID outputs
stall_idex  out  1  hold IDEX register
bubble_idex  out  1  load NOP into IDEX
flush_front  out  1  clear IFID, IDEX, ID state
flush_rob  out  1  clear ROB / rename state
jump_ce  out  1  1-cycle fetch redirect strobe
jump_pc  out  ADDR_W  redirect target
ctrl_state  out  2  current FSM state, for debug

Behaviour:
- Reset (rst=0, async): state=RUN, flush cnt=0, refill cnt=0, jump_pc=0. jump_ce=0 and all flush_* = 0. Stall and bubble outputs are 0 while in reset.
- FSM states: RUN=0, FLUSH=1, REFILL=2. Encoding 3 is unused and returns to RUN.
- Stall/bubble outputs are combinational from the current state and request inputs. jump_ce, jump_pc and flush_* are registered.
- RUN, priority redirect > ex_stall > id_stall:
  - ex_stall_req=1: stall_if, stall_ifid, stall_id, stall_idex=1; bubble_idex=0.
  - Only id_stall_req=1: stall_if, stall_ifid, stall_id=1; stall_idex=0; bubble_idex=1.
  - No request: all 0.
- rob_redirect_valid=1 in any state:
  - Next cycle: state=FLUSH, jump_pc<=rob_redirect_pc, jump_ce=1 for exactly that one cycle.
  - flush_front=flush_rob=1, flush cnt loaded with FLUSH_CYCLES-1.
  - Stall requests arriving in the same cycle are ignored.
- FLUSH:
  - flush_front and flush_rob stay asserted; all stall outputs and bubble_idex = 0.
  - cnt decrements each cycle. When cnt==0 (end of that cycle) go to REFILL, deassert flushes, clear refill cnt.
  - A new redirect during FLUSH restarts FLUSH: new jump_pc, new jump_ce pulse, cnt reloaded.
- REFILL:
  - Stall outputs behave as in RUN.
  - Go to RUN on if_fetch_valid=1, or when refill cnt reaches REFILL_MAX-1.
  - A redirect during REFILL follows the redirect rule above.
- jump_pc holds its last value after jump_ce drops.
- Reset mid-FLUSH aborts immediately; flush outputs drop asynchronously.
- With FLUSH_CYCLES=1, FLUSH lasts exactly one cycle.

Optional Feature:
PIPE_CTRL_PERF_EN:
- When defined, adds 32-bit saturating counters plus output ports: perf_stall_cycles (cycles with stall_if=1), perf_flush_count (redirects accepted) and perf_refill_cycles (cycles spent in REFILL).
- Counters reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined, these ports and counters do not exist, and core behaviour is identical.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - typedef enum logic[1:0] ctrl_state_t {RUN, FLUSH, REFILL}
  - localparam defaults for ADDR_W and FLUSH_CYCLES
  - packed struct stage_ctrl_t {stall_if, stall_ifid, stall_id, stall_idex, bubble_idex, flush_front, flush_rob}, for later interface bundling
- One natural sub-module: pipe_ctrl_perf (counter bank), instantiated only under PIPE_CTRL_PERF_EN.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all inputs=1 -> all outputs 0, ctrl_state=0. After release with no requests -> outputs stay 0.
- id_stall_req=1 for 4 cycles in RUN -> stall_if, stall_ifid, stall_id=1 and bubble_idex=1 in each of those cycles, stall_idex=0. All drop in the cycle the request drops.
- ex_stall_req=1 together with id_stall_req=1 -> all four stalls=1, bubble_idex=0.
- Redirect pulse with pc=32'h0000_0100, FLUSH_CYCLES=2:
  - next cycle: jump_ce=1, jump_pc=32'h100, flush_*=1 for 2 cycles;
  - then REFILL;
  - if_fetch_valid=1 one cycle later -> RUN.
- Second redirect to 32'h200 in the 2nd FLUSH cycle -> a new jump_ce pulse with 32'h200, and flush extended a further 2 cycles.
- REFILL with if_fetch_valid held 0 -> returns to RUN after 8 cycles. With PIPE_CTRL_PERF_EN, perf_refill_cycles=8 and perf_flush_count=1.
